// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator.
// Handles prioritised redirects, fetch backpressure and a misaligned-target halt.
module pc_gen_unit #(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
  parameter int                IALIGN       = 4
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [DWIDTH-1:0] Flush_Target,
  input  logic              Trap,
  input  logic [DWIDTH-1:0] Trap_Vector,
  input  logic              Fetch_Ready,
  output logic              Fetch_Valid,
  output logic [DWIDTH-1:0] Program_Count,
  output logic [DWIDTH-1:0] Program_Count_Plus,
  output logic              Misaligned,
  output logic [DWIDTH-1:0] Misaligned_Addr
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [DWIDTH-1:0] AMASK = DWIDTH'(IALIGN - 1);
  localparam logic [DWIDTH-1:0] INC   = DWIDTH'(IALIGN);

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              mis_q, mis_d;
  logic [DWIDTH-1:0] mis_addr_q, mis_addr_d;

  logic [DWIDTH-1:0] trap_pc;
  logic [DWIDTH-1:0] pc_plus;
  logic              tgt_bad;

  assign trap_pc = Trap_Vector & ~AMASK;
  assign pc_plus = pc_q + INC;
  assign tgt_bad = |(Flush_Target & AMASK);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (Trap) begin
          pc_d = trap_pc;
        end else if (Flush && !tgt_bad) begin
          pc_d = Flush_Target;
        end else if (Flush) begin
          // PC is frozen; only a trap can leave HALT
          mis_d      = 1'b1;
          mis_addr_d = Flush_Target;
          state_d    = S_HALT;
        end else if (!Stall && Fetch_Ready) begin
          pc_d = pc_plus;
        end
      end
      S_HALT: begin
        if (Trap) begin
          pc_d    = trap_pc;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign Fetch_Valid        = (state_q == S_RUN);
  assign Program_Count      = pc_q;
  assign Program_Count_Plus = pc_plus;
  assign Misaligned         = mis_q;
  assign Misaligned_Addr    = mis_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: IALIGN=4 and IALIGN=2 instances share stimulus,
// each compared against an arithmetic reference model.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, trap, ready;
  logic [31:0] ftgt, tvec;

  logic        v4, m4, v2, m2;
  logic [31:0] pc4, pl4, ma4, pc2, pl2, ma2;

  int total = 0;
  int bad   = 0;

  // reference model, index 0 -> IALIGN 4, index 1 -> IALIGN 2
  int     ia    [2] = '{4, 2};
  int     phase [2];
  longint m_pc  [2];
  bit     m_mis [2];
  longint m_ma  [2];

  localparam longint MOD = 64'h1_0000_0000;

  always #5 clk = ~clk;

  pc_gen_unit #(.DWIDTH(32), .RESET_VECTOR(32'h0), .IALIGN(4)) u4 (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Stall(stall), .Flush(flush),
    .Flush_Target(ftgt), .Trap(trap), .Trap_Vector(tvec),
    .Fetch_Ready(ready), .Fetch_Valid(v4), .Program_Count(pc4),
    .Program_Count_Plus(pl4), .Misaligned(m4), .Misaligned_Addr(ma4)
  );

  pc_gen_unit #(.DWIDTH(32), .RESET_VECTOR(32'h0), .IALIGN(2)) u2 (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Stall(stall), .Flush(flush),
    .Flush_Target(ftgt), .Trap(trap), .Trap_Vector(tvec),
    .Fetch_Ready(ready), .Fetch_Valid(v2), .Program_Count(pc2),
    .Program_Count_Plus(pl2), .Misaligned(m2), .Misaligned_Addr(ma2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0;
      m_pc[k]  = 0;
      m_mis[k] = 0;
      m_ma[k]  = 0;
    end
  endfunction

  function automatic void model_step();
    longint tv, ft;
    tv = longint'(tvec);
    ft = longint'(ftgt);
    for (int k = 0; k < 2; k++) begin
      m_mis[k] = 0;
      if (phase[k] == 0) begin
        phase[k] = 1;
      end else if (phase[k] == 1) begin
        if (trap) m_pc[k] = tv - (tv % ia[k]);
        else if (flush && (ft % ia[k]) != 0) begin
          m_mis[k] = 1;
          m_ma[k]  = ft;
          phase[k] = 2;
        end else if (flush) m_pc[k] = ft;
        else if (!stall && ready) m_pc[k] = (m_pc[k] + ia[k]) % MOD;
      end else if (trap) begin
        m_pc[k]  = tv - (tv % ia[k]);
        phase[k] = 1;
      end
    end
  endfunction

  task automatic check_all();
    chk("pc4",    pc4, 32'(m_pc[0]));
    chk("plus4",  pl4, 32'((m_pc[0] + 4) % MOD));
    chk("valid4", {31'd0, v4}, {31'd0, phase[0] == 1});
    chk("mis4",   {31'd0, m4}, {31'd0, m_mis[0]});
    chk("maddr4", ma4, 32'(m_ma[0]));
    chk("pc2",    pc2, 32'(m_pc[1]));
    chk("plus2",  pl2, 32'((m_pc[1] + 2) % MOD));
    chk("valid2", {31'd0, v2}, {31'd0, phase[1] == 1});
    chk("mis2",   {31'd0, m2}, {31'd0, m_mis[1]});
    chk("maddr2", ma2, 32'(m_ma[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; flush = 0; trap = 0; ready = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    ftgt = 0;
    tvec = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check_all();

    // 1: run to 0x40, then asynchronous reset between edges
    step();
    ready = 1;
    for (int i = 0; i < 16; i++) step();
    chk("t1_pc40", pc4, 32'h40);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("t1_rst_pc", pc4, 32'h0);
    chk("t1_rst_v", {31'd0, v4}, 32'd0);
    check_all();
    #1;
    rst_n = 1;
    ready = 0;
    #1;
    chk("t1_boot_v", {31'd0, v4}, 32'd0);
    step();
    chk("t1_run_v", {31'd0, v4}, 32'd1);
    chk("t1_run_pc", pc4, 32'h0);

    // 2: backpressure
    ready = 1; step(); chk("t2_a", pc4, 32'h4);
    ready = 0; step(); chk("t2_b", pc4, 32'h4);
    step();            chk("t2_c", pc4, 32'h4);
    ready = 1; step(); chk("t2_d", pc4, 32'h8);
    step();            chk("t2_e", pc4, 32'hC);

    // 3: stall versus flush
    idle(); flush = 1; ftgt = 32'h10; step();
    idle(); stall = 1; ready = 1; step();
    chk("t3_a", pc4, 32'h10);
    flush = 1; ftgt = 32'h100; step();
    chk("t3_b", pc4, 32'h100);
    flush = 0; step();
    chk("t3_c", pc4, 32'h100);

    // 4: trap beats flush, vector is aligned down
    idle(); trap = 1; tvec = 32'h203; flush = 1; ftgt = 32'h80; step();
    chk("t4_pc4", pc4, 32'h200);
    chk("t4_pc2", pc2, 32'h202);
    chk("t4_mis", {31'd0, m4}, 32'd0);

    // 5: misaligned target halts IALIGN=4, accepted by IALIGN=2
    idle(); flush = 1; ftgt = 32'h20; step();
    ftgt = 32'h102; step();
    chk("t5_mis", {31'd0, m4}, 32'd1);
    chk("t5_maddr", ma4, 32'h102);
    chk("t5_v", {31'd0, v4}, 32'd0);
    chk("t5_pc", pc4, 32'h20);
    chk("t5_pc2", pc2, 32'h102);
    stall = 1; ftgt = 32'h40; step();
    chk("t5_pulse", {31'd0, m4}, 32'd0);
    chk("t5_hold", pc4, 32'h20);
    idle(); trap = 1; tvec = 32'h300; step();
    chk("t5_trap_pc", pc4, 32'h300);
    chk("t5_trap_v", {31'd0, v4}, 32'd1);

    // 6: wrap-around
    idle(); flush = 1; ftgt = 32'hFFFF_FFFC; step();
    chk("t6_plus", pl4, 32'h0);
    idle(); ready = 1; step();
    chk("t6_wrap", pc4, 32'h0);

    // randomized traffic with occasional async reset
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 5) == 0;
      trap  = ($urandom % 9) == 0;
      ready = ($urandom % 3) != 0;
      ftgt  = $urandom;
      if ($urandom % 2 == 0) ftgt[1:0] = 2'b00;
      tvec  = $urandom;
      if ($urandom % 60 == 0) begin
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the fetch stage. It extends a plain PC register with the following:
- reset-vector and instruction-alignment parameters
- a valid/ready fetch request handshake toward instruction memory
- prioritised redirect sources: trap, then flush/branch, then stall, then sequential
- misaligned-target detection with a halt state that only a trap can exit

It sits between the execute/trap logic and the instruction-memory interface.

Parameters:
DWIDTH, 32, PC and address width in bits (16..64).
RESET_VECTOR, 32'h0000_0000, PC value held during and after reset. Must be IALIGN-aligned.
IALIGN, 4, instruction alignment in bytes. Legal values are 2 or 4. It is also the sequential increment.

Ports:
Clk_Core  input  1  core clock, rising-edge.
Rst_Core_N  input  1  core reset, asynchronous, active-low.
Stall  input  1  decode stall; holds the PC.
Flush  input  1  branch/jump redirect from execute.
Flush_Target  input  DWIDTH  redirect address, sampled when Flush=1.
Trap  input  1  trap/exception entry request.
Trap_Vector  input  DWIDTH  trap handler address.
Fetch_Ready  input  1  instruction memory accepts the current request.
Fetch_Valid  output  1  request valid; Program_Count is the fetch address.
Program_Count  output  DWIDTH  current fetch PC (registered).
Program_Count_Plus  output  DWIDTH  Program_Count + IALIGN, combinational, modulo 2^DWIDTH.
Misaligned  output  1  one-cycle pulse: the flush target violated IALIGN.
Misaligned_Addr  output  DWIDTH  offending target. Registered; holds until the next misalignment or reset.

Behaviour:
- Reset (Rst_Core_N=0, asynchronous): takes effect immediately and is independent of the clock.
  - Program_Count=RESET_VECTOR, Fetch_Valid=0, Misaligned=0, Misaligned_Addr=0, state=BOOT.
- State machine states: BOOT, RUN, HALT. Encoding is free.
- BOOT:
  - Fetch_Valid=0; PC holds RESET_VECTOR.
  - The first clock edge after reset release goes to RUN unconditionally.
  - Trap/Flush are ignored in BOOT.
- RUN:
  - Fetch_Valid=1.
  - Next-PC priority is evaluated every edge:
    1. Trap=1: PC <= Trap_Vector with bits [log2(IALIGN)-1:0] forced to 0; stay in RUN.
    2. Else Flush=1 and Flush_Target aligned: PC <= Flush_Target.
    3. Else Flush=1 and Flush_Target misaligned (any of bits [log2(IALIGN)-1:0] set):
       - PC unchanged.
       - Misaligned=1 for exactly the next cycle.
       - Misaligned_Addr <= Flush_Target.
       - state <= HALT.
    4. Else Stall=1: PC held.
    5. Else Fetch_Ready=1: PC <= Program_Count_Plus.
    6. Else PC held (backpressure).
  - Trap and Flush override Stall and Fetch_Ready. A redirect may change the address while a request is pending unaccepted; this is the only permitted change of a valid, unaccepted address.
- HALT:
  - Fetch_Valid=0; PC held.
  - Flush and Stall are ignored.
  - Trap=1 loads the aligned Trap_Vector and goes to RUN; Fetch_Valid=1 from the next cycle.
- Arithmetic: the increment wraps modulo 2^DWIDTH, with no overflow flag.
- Latency: every redirect is visible on Program_Count one cycle after it is sampled.
- Misaligned is combinationally independent of the inputs (registered).
- Reset asserted mid-operation (any state) immediately forces the reset values. Any pending HALT or Misaligned pulse is discarded.

Test Plan:
1. Reset and boot: run to PC=0x40, then pulse Rst_Core_N low between edges. Program_Count=0x0 and Fetch_Valid=0 immediately. After release: one cycle with Fetch_Valid=0, then Fetch_Valid=1 at PC=0x0.
2. Backpressure: RUN at PC=0x0 with Fetch_Ready=1,0,0,1,1 on successive edges. PC sequence is 0x4,0x4,0x4,0x8,0xC; Fetch_Valid stays 1.
3. Stall vs flush: Stall=1 for 3 cycles at PC=0x10, with Flush=1 and target 0x100 on the second. PC=0x10, then 0x100, then held at 0x100 while Stall remains high.
4. Priority: Trap=1 with Trap_Vector=0x203, plus Flush=1 with target 0x80, in the same cycle. PC=0x200 next cycle; Misaligned=0.
5. Misaligned halt (IALIGN=4): Flush target 0x102 at PC=0x20.
   - Next cycle: Misaligned=1 (one cycle only), Misaligned_Addr=0x102, Fetch_Valid=0, PC=0x20.
   - Further Flush and Stall are ignored.
   - Trap with vector 0x300 gives PC=0x300 and Fetch_Valid=1. Repeat with IALIGN=2: target 0x102 is accepted.
6. Wrap-around: force PC=0xFFFF_FFFC via Flush, then Fetch_Ready=1. Program_Count_Plus=0x0 and PC=0x0000_0000 next cycle.
